// File: rtl/test_pulse_sequencer.sv
// Avalon-MM scheduler firing timed bursts of start strobes to the pulse generator.
// Define TEST_SEQ_IRQ_EN to add the level irq output and the CTRL irq_en bit.
module test_pulse_sequencer #(
    parameter int PERIOD_W = 24,
    parameter int COUNT_W  = 16
) (
    input  logic        avmm_clk,
    input  logic        avmm_reset,
    input  logic        avmm_cs,
    input  logic [1:0]  avmm_addr,
    input  logic        avmm_write,
    input  logic [31:0] avmm_writedata,
    input  logic        avmm_read,
    output logic [31:0] avmm_readdata,
    input  logic        meas_done,
    output logic        trig_out,
    output logic        busy
`ifdef TEST_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FIRE, S_GAP} state_t;

    state_t              r_state;
    logic                r_trig;
    logic                r_busy;
    logic [31:0]         r_rdata;
    logic [PERIOD_W-1:0] r_period;
    logic [COUNT_W-1:0]  r_count;
    logic                r_cont;
    logic                r_wait;
    logic                r_irq_en;
    logic                r_done;
    logic                r_timeout;
    logic                r_aborted;
    logic [COUNT_W-1:0]  r_fired;
    logic [7:0]          r_tocnt;
    logic                r_w_cont;
    logic                r_w_wait;
    logic [COUNT_W-1:0]  r_remain;
    logic [PERIOD_W-1:0] r_gap_load;
    logic [PERIOD_W-1:0] r_gap;
    logic                r_seen;

    logic                w_wr;
    logic                w_wr_ctrl;
    logic                w_start;
    logic                w_abort;
    logic                w_seen;
    logic                w_more;
    logic [PERIOD_W-1:0] w_per_eff;
    logic [31:0]         w_rmux;
    logic                w_unused;

    assign w_wr      = avmm_cs & avmm_write;
    assign w_wr_ctrl = w_wr & (avmm_addr == 2'd0);
    assign w_abort   = w_wr_ctrl & avmm_writedata[1];
    assign w_start   = w_wr_ctrl & avmm_writedata[0] & ~avmm_writedata[1];
    assign w_seen    = r_seen | meas_done;
    assign w_more    = (r_remain != '0) | r_w_cont;
    assign w_per_eff = (r_period < PERIOD_W'(2)) ? PERIOD_W'(2) : r_period;
    assign w_unused  = ^avmm_writedata;

    always_ff @(posedge avmm_clk or posedge avmm_reset) begin
        if (avmm_reset) begin
            r_state    <= S_IDLE;
            r_trig     <= 1'b0;
            r_busy     <= 1'b0;
            r_period   <= '0;
            r_count    <= '0;
            r_cont     <= 1'b0;
            r_wait     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_aborted  <= 1'b0;
            r_fired    <= '0;
            r_tocnt    <= '0;
            r_w_cont   <= 1'b0;
            r_w_wait   <= 1'b0;
            r_remain   <= '0;
            r_gap_load <= '0;
            r_gap      <= '0;
            r_seen     <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_cont <= avmm_writedata[2];
                r_wait <= avmm_writedata[3];
`ifdef TEST_SEQ_IRQ_EN
                r_irq_en <= avmm_writedata[4];
`else
                r_irq_en <= 1'b0;
`endif
            end
            if (w_wr && avmm_addr == 2'd1)
                r_period <= avmm_writedata[PERIOD_W-1:0];
            if (w_wr && avmm_addr == 2'd2)
                r_count <= avmm_writedata[COUNT_W-1:0];
            // Clears come first so a same-cycle set from the FSM wins.
            if (w_wr && avmm_addr == 2'd3) begin
                if (avmm_writedata[1]) r_done    <= 1'b0;
                if (avmm_writedata[2]) r_timeout <= 1'b0;
                if (avmm_writedata[3]) r_aborted <= 1'b0;
            end
            r_trig <= 1'b0;
            if (w_abort) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_aborted <= 1'b1;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_fired    <= '0;
                            r_tocnt    <= '0;
                            r_w_cont   <= avmm_writedata[2];
                            r_w_wait   <= avmm_writedata[3];
                            r_remain   <= r_count;
                            r_gap_load <= w_per_eff - PERIOD_W'(2);
                            if (r_count != '0 || avmm_writedata[2]) begin
                                r_state <= S_FIRE;
                                r_busy  <= 1'b1;
                                r_trig  <= 1'b1;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_FIRE: begin
                        r_fired  <= r_fired + 1'b1;
                        r_remain <= r_remain - 1'b1;
                        r_seen   <= meas_done;
                        r_gap    <= r_gap_load;
                        r_state  <= S_GAP;
                    end
                    S_GAP: begin
                        if (r_gap != '0) begin
                            r_gap  <= r_gap - 1'b1;
                            r_seen <= w_seen;
                        end else begin
                            if (r_w_wait && !w_seen) begin
                                r_timeout <= 1'b1;
                                if (r_tocnt != 8'hFF)
                                    r_tocnt <= r_tocnt + 1'b1;
                            end
                            if (w_more) begin
                                r_state <= S_FIRE;
                                r_trig  <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // CTRL readback keeps the stored mode bits at [9:8].
    always_comb begin
        w_rmux = '0;
        unique case (avmm_addr)
            2'd0: w_rmux = {22'b0, r_wait, r_cont, 3'b0, r_irq_en,
                            r_aborted, r_timeout, r_done, r_busy};
            2'd1: w_rmux = 32'(r_period);
            2'd2: w_rmux = 32'(r_count);
            2'd3: begin
                w_rmux[31:24]        = r_tocnt;
                w_rmux[COUNT_W-1:0]  = r_fired;
            end
            default: w_rmux = '0;
        endcase
    end

    always_ff @(posedge avmm_clk or posedge avmm_reset) begin
        if (avmm_reset)
            r_rdata <= '0;
        else if (avmm_cs && avmm_read)
            r_rdata <= w_rmux;
    end

    assign avmm_readdata = r_rdata;
    assign trig_out      = r_trig;
    assign busy          = r_busy;
`ifdef TEST_SEQ_IRQ_EN
    assign irq = r_irq_en & (r_done | r_timeout | r_aborted);
`endif

endmodule

// File: tb/tb_test_pulse_sequencer.sv
// Randomized bench for test_pulse_sequencer against a per-cycle schedule model.
`timescale 1ns/1ps
module tb_test_pulse_sequencer;
    localparam int MAXC = 8192;
`ifdef TEST_SEQ_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, wr = 1'b0, rd = 1'b0, md = 1'b0;
    logic [1:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        trig, busy;
`ifdef TEST_SEQ_IRQ_EN
    logic        irq;
`endif

    int vec = 0;
    int bad = 0;
    int cyc = 0;
    bit exp_trig[MAXC];
    bit exp_busy[MAXC];
    bit md_arr[MAXC];
    int trig_q[$];

    bit m_done, m_to, m_ab, m_cont, m_wait, m_irqen;
    int m_fired, m_tocnt;
    logic [31:0] m_per, m_cnt;

    test_pulse_sequencer dut (
        .avmm_clk(clk), .avmm_reset(rst), .avmm_cs(cs),
        .avmm_addr(addr), .avmm_write(wr), .avmm_writedata(wdata),
        .avmm_read(rd), .avmm_readdata(rdata), .meas_done(md),
        .trig_out(trig), .busy(busy)
`ifdef TEST_SEQ_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, act, exp);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        md = (cyc < MAXC) ? md_arr[cyc] : 1'b0;
    end

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            chk("trig_out", {31'b0, trig}, {31'b0, exp_trig[cyc]});
            chk("busy", {31'b0, busy}, {31'b0, exp_busy[cyc]});
            if (trig === 1'b1) trig_q.push_back(cyc);
        end
    end

    initial begin
        #(MAXC * 10 + 1000);
        $display("FAIL watchdog: simulation exceeded %0d cycles", MAXC);
        $fatal(1, "watchdog");
    end

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, output int s);
        @(posedge clk); #1;
        cs = 1; wr = 1; addr = a; wdata = d; s = cyc;
        @(posedge clk); #1;
        cs = 0; wr = 0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        cs = 1; rd = 1; addr = a;
        @(posedge clk); #1;
        cs = 0; rd = 0; d = rdata;
    endtask

    task automatic w1c(input logic [31:0] mask);
        int s;
        bus_wr(2'd3, mask, s);
        if (mask[1]) m_done = 0;
        if (mask[2]) m_to = 0;
        if (mask[3]) m_ab = 0;
    endtask

    task automatic check_regs(string tag);
        logic [31:0] r;
        bus_rd(2'd0, r);
        chk({tag, "_ctrl"}, r, {22'b0, m_wait, m_cont, 3'b0, m_irqen,
                                m_ab, m_to, m_done, 1'b0});
        bus_rd(2'd3, r);
        chk({tag, "_status"}, r, {m_tocnt[7:0], 8'b0, m_fired[15:0]});
`ifdef TEST_SEQ_IRQ_EN
        chk({tag, "_irq"}, {31'b0, irq},
            {31'b0, m_irqen & (m_done | m_to | m_ab)});
`endif
    endtask

    // Accepted start in cycle s: triggers at s+1+k*pe, busy until s+n*pe.
    task automatic do_start(input int p, input int n, input bit cont,
                            input bit wd, input bit ie, input bit rnd,
                            input logic [31:0] hit, output int s);
        int pe, miss, off, last, tmp;
        bit give;
        pe = (p < 2) ? 2 : p;
        bus_wr(2'd1, p, tmp);
        bus_wr(2'd2, n, tmp);
        m_per = p & 32'h00FF_FFFF;
        m_cnt = n & 32'h0000_FFFF;
        @(posedge clk); #1;
        s = cyc;
        miss = 0;
        if (!cont) begin
            for (int i = 0; i < n; i++) begin
                give = rnd ? ($urandom_range(3) != 0) : (i < 32 && hit[i]);
                if (give) begin
                    off = $urandom_range(pe - 1);
                    if (s + 1 + i * pe + off < MAXC) md_arr[s + 1 + i * pe + off] = 1;
                end else begin
                    miss++;
                end
            end
        end
        cs = 1; wr = 1; addr = 2'd0;
        wdata = {27'b0, ie, wd, cont, 1'b0, 1'b1};
        @(posedge clk); #1;
        cs = 0; wr = 0;
        m_cont = cont; m_wait = wd; m_irqen = IRQ & ie;
        m_fired = cont ? 0 : n;
        m_tocnt = wd ? ((miss > 255) ? 255 : miss) : 0;
        if (wd && miss > 0 && !cont) m_to = 1;
        if (n == 0 && !cont) begin
            m_done = 1;
        end else begin
            last = cont ? MAXC - 1 : s + n * pe;
            if (!cont) m_done = 1;
            for (int c = s + 1; c <= last && c < MAXC; c++) begin
                exp_busy[c] = 1;
                if ((c - s - 1) % pe == 0) exp_trig[c] = 1;
            end
        end
    endtask

    task automatic wait_end(input int s, input int p, input int n);
        int pe;
        pe = (p < 2) ? 2 : p;
        while (cyc < s + n * pe + 2) @(posedge clk);
        #1;
    endtask

    task automatic m_abort(input int a);
        for (int c = a + 1; c < MAXC; c++) begin
            exp_busy[c] = 0;
            exp_trig[c] = 0;
        end
        m_ab = 1;
    endtask

    initial begin
        int s, a, p, n, tmp;
        logic [31:0] r;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("reset_readdata", rdata, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus_rd(i[1:0], r);
            chk("reset_reg", r, 32'h0);
        end

        bus_wr(2'd1, 32'hFFFF_FFFF, tmp);
        bus_rd(2'd1, r);
        chk("period_width", r, 32'h00FF_FFFF);

        // Basic burst: PERIOD=10, COUNT=3.
        trig_q.delete();
        do_start(10, 3, 0, 0, 0, 0, '0, s);
        wait_end(s, 10, 3);
        chk("burst_npulses", trig_q.size(), 3);
        if (trig_q.size() >= 3) begin
            chk("burst_space1", trig_q[1] - trig_q[0], 10);
            chk("burst_space2", trig_q[2] - trig_q[1], 10);
        end
        check_regs("burst");
        bus_rd(2'd3, r);
        chk("burst_fired_lit", r, 32'h0000_0003);

        // wait_done with a missing measurement on trigger 3.
        w1c(32'hE);
        do_start(8, 4, 0, 1, 1, 0, 32'b1011, s);
        wait_end(s, 8, 4);
        check_regs("waitdone");
        bus_rd(2'd3, r);
        chk("waitdone_lit", r, 32'h0100_0004);
`ifdef TEST_SEQ_IRQ_EN
        chk("irq_on_done", {31'b0, irq}, 32'h1);
        w1c(32'hE);
        chk("irq_after_w1c", {31'b0, irq}, 32'h0);
`else
        w1c(32'hE);
`endif

        // Continuous, abort after the third trigger.
        trig_q.delete();
        do_start(5, 0, 1, 0, 0, 0, '0, s);
        while (cyc < s + 11) @(posedge clk);
        #1;
        bus_wr(2'd0, 32'h2, a);
        m_cont = 0; m_wait = 0; m_irqen = 0;
        m_fired = 0;
        for (int c = s + 1; c < a; c++) m_fired += exp_trig[c];
        m_abort(a);
        repeat (12) @(posedge clk);
        #1;
        chk("cont_npulses", trig_q.size(), 3);
        check_regs("abort");
        w1c(32'h8);

        // PERIOD 0 and 1 both give a spacing of 2.
        for (int pv = 0; pv < 2; pv++) begin
            trig_q.delete();
            do_start(pv, 3, 0, 0, 0, 0, '0, s);
            wait_end(s, pv, 3);
            chk("short_npulses", trig_q.size(), 3);
            if (trig_q.size() >= 2)
                chk("short_space", trig_q[1] - trig_q[0], 2);
            check_regs("short");
        end

        // COUNT=0: no trigger, done set.
        w1c(32'hE);
        trig_q.delete();
        do_start(4, 0, 0, 0, 0, 0, '0, s);
        wait_end(s, 4, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("count0_npulses", trig_q.size(), 0);
        check_regs("count0");

        // Start while busy is ignored; register writes only stage values.
        w1c(32'hE);
        do_start(6, 4, 0, 0, 0, 0, '0, s);
        bus_wr(2'd0, 32'h5, tmp);
        m_cont = 1; m_wait = 0; m_irqen = 0;
        bus_wr(2'd1, 3, tmp);
        m_per = 3;
        wait_end(s, 6, 4);
        check_regs("busy_start");
        bus_rd(2'd1, r);
        chk("staged_period", r, m_per);
        bus_wr(2'd0, 32'h3, a);
        m_cont = 0;
        m_abort(a);
        repeat (4) @(posedge clk);
        #1;
        check_regs("start_abort");

        // Randomized bursts.
        for (int k = 0; k < 20; k++) begin
            w1c({28'b0, 3'($urandom_range(7)), 1'b0});
            p = $urandom_range(12);
            n = $urandom_range(6);
            do_start(p, n, 0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                     1, '0, s);
            wait_end(s, p, n);
            check_regs("rand");
            bus_rd(2'd2, r);
            chk("rand_count", r, m_cnt);
        end

        // Timeout counter saturation.
        w1c(32'hE);
        do_start(2, 300, 0, 1, 0, 0, '0, s);
        wait_end(s, 2, 300);
        check_regs("saturate");

        // Reset in the middle of a gap.
        do_start(10, 3, 0, 0, 0, 0, '0, s);
        while (cyc < s + 4) @(posedge clk);
        #2;
        rst = 1;
        for (int c = cyc; c < MAXC; c++) begin
            exp_busy[c] = 0;
            exp_trig[c] = 0;
            md_arr[c] = 0;
        end
        #1;
        chk("rst_trig", {31'b0, trig}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        m_done = 0; m_to = 0; m_ab = 0; m_cont = 0; m_wait = 0; m_irqen = 0;
        m_fired = 0; m_tocnt = 0; m_per = 0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_readdata", rdata, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus_rd(i[1:0], r);
            chk("rst_reg", r, 32'h0);
        end
        check_regs("post_reset");

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
